// File: rtl/ethpipe_rx_slot_ctrl.sv
// ethpipe_rx_slot_ctrl: PCI-side scheduler for the RX frame slot buffer.
// It arms one slot at a time for the GMII receiver. On each rx_complete it
// latches the frame length and timestamp into that slot's descriptor. It
// presents committed frames to the host in FIFO order and frees a slot on
// each host release.
// Optional build macro ETHPIPE_RX_STATS_EN adds the stat_rx_frames and
// stat_rx_ignored counters.
module ethpipe_rx_slot_ctrl #(
  parameter int NUM_SLOTS    = 4,
  parameter int SLOT_W       = 2,
  parameter int GUARD_CYCLES = 4
) (
  input  logic              pci_clk,
  input  logic              sys_rst,
  input  logic              rx_enable,
  input  logic              rx_complete,
  input  logic [11:0]       rx_frame_len,
  input  logic [63:0]       rx_timestamp,
  output logic              rx_empty,
  output logic [SLOT_W-1:0] rx_slot_sel,
  output logic              host_rx_valid,
  output logic [SLOT_W-1:0] host_rx_slot,
  output logic [11:0]       host_rx_len,
  output logic [63:0]       host_rx_ts,
  input  logic              host_rx_release,
  output logic [SLOT_W:0]   rx_count
`ifdef ETHPIPE_RX_STATS_EN
  ,
  output logic [31:0]       stat_rx_frames,
  output logic [31:0]       stat_rx_ignored
`endif
);

  localparam logic [SLOT_W:0] FULL       = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [3:0]      GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, ARMED, COMMIT, GUARD} state_t;

  state_t            state, state_nxt;
  logic [SLOT_W-1:0] wr_ptr, rd_ptr;
  logic [SLOT_W:0]   count;
  logic [3:0]        guard_cnt;
  logic [11:0]       hold_len;
  logic [63:0]       hold_ts;
  logic [11:0]       desc_len [NUM_SLOTS];
  logic [63:0]       desc_ts  [NUM_SLOTS];
  logic              commit, release_ok, capture;

  assign commit     = (state == COMMIT);
  assign capture    = (state == ARMED) && rx_complete;
  assign release_ok = host_rx_release && (count != '0);

  // State register.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) state <= HOLD;
    else         state <= state_nxt;
  end

  // Next-state decode; COMMIT and GUARD always run to completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      HOLD:    if (rx_enable && (count < FULL)) state_nxt = ARMED;
      ARMED: begin
        if (rx_complete)     state_nxt = COMMIT;
        else if (!rx_enable) state_nxt = HOLD;
      end
      COMMIT:  state_nxt = GUARD;
      GUARD:   if (guard_cnt == '0) state_nxt = HOLD;
      default: state_nxt = HOLD;
    endcase
  end

  // Ring pointers, pending count and guard timer; commit and release may coincide.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      guard_cnt <= '0;
    end else begin
      if (commit)     wr_ptr <= wr_ptr + 1'b1;
      if (release_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, release_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (commit)
        guard_cnt <= GUARD_LOAD;
      else if ((state == GUARD) && (guard_cnt != '0))
        guard_cnt <= guard_cnt - 1'b1;
    end
  end

  // Holding registers capture the frame info on the pulse, ahead of the commit.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_len <= '0;
      hold_ts  <= '0;
    end else if (capture) begin
      hold_len <= rx_frame_len;
      hold_ts  <= rx_timestamp;
    end
  end

  // Per-slot descriptor table, written once per commit.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        desc_len[i] <= '0;
        desc_ts[i]  <= '0;
      end
    end else if (commit) begin
      desc_len[wr_ptr] <= hold_len;
      desc_ts[wr_ptr]  <= hold_ts;
    end
  end

`ifdef ETHPIPE_RX_STATS_EN
  logic [31:0] frames_cnt, ignored_cnt;

  // Wrapping statistics: commits, and pulses that arrive while not armed.
  always_ff @(posedge pci_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frames_cnt  <= '0;
      ignored_cnt <= '0;
    end else begin
      if (commit)                          frames_cnt  <= frames_cnt + 32'd1;
      if (rx_complete && (state != ARMED)) ignored_cnt <= ignored_cnt + 32'd1;
    end
  end

  assign stat_rx_frames  = frames_cnt;
  assign stat_rx_ignored = ignored_cnt;
`endif

  assign rx_empty      = (state == ARMED);
  assign rx_slot_sel   = wr_ptr;
  assign host_rx_valid = (count != '0);
  assign host_rx_slot  = rd_ptr;
  assign host_rx_len   = desc_len[rd_ptr];
  assign host_rx_ts    = desc_ts[rd_ptr];
  assign rx_count      = count;

endmodule

// File: tb/tb_ethpipe_rx_slot_ctrl.sv
// Bench for ethpipe_rx_slot_ctrl. It combines directed steps with a
// randomized phase. A timeline/queue reference model supplies the expected
// outputs every cycle.
module tb_ethpipe_rx_slot_ctrl;

  localparam int N = 4;
  localparam int W = 2;
  localparam int G = 4;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          rx_enable = 1'b0;
  logic          rx_complete = 1'b0;
  logic [11:0]   rx_frame_len = '0;
  logic [63:0]   rx_timestamp = '0;
  logic          host_rx_release = 1'b0;
  logic          rx_empty, host_rx_valid;
  logic [W-1:0]  rx_slot_sel, host_rx_slot;
  logic [11:0]   host_rx_len;
  logic [63:0]   host_rx_ts;
  logic [W:0]    rx_count;
`ifdef ETHPIPE_RX_STATS_EN
  logic [31:0]   stat_rx_frames, stat_rx_ignored;
`endif

  ethpipe_rx_slot_ctrl #(.NUM_SLOTS(N), .SLOT_W(W), .GUARD_CYCLES(G)) dut (
    .pci_clk(clk), .sys_rst(sys_rst), .rx_enable(rx_enable),
    .rx_complete(rx_complete), .rx_frame_len(rx_frame_len),
    .rx_timestamp(rx_timestamp), .rx_empty(rx_empty),
    .rx_slot_sel(rx_slot_sel), .host_rx_valid(host_rx_valid),
    .host_rx_slot(host_rx_slot), .host_rx_len(host_rx_len),
    .host_rx_ts(host_rx_ts), .host_rx_release(host_rx_release),
    .rx_count(rx_count)
`ifdef ETHPIPE_RX_STATS_EN
    , .stat_rx_frames(stat_rx_frames), .stat_rx_ignored(stat_rx_ignored)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a FIFO of committed frames plus a timeline of edges.
  typedef struct {
    logic [11:0] len;
    logic [63:0] ts;
    int          slot;
  } frame_t;

  frame_t      q[$];
  int          m_k = 0;
  bit          m_armed = 0;
  int          m_commit_edge = -1;
  logic [11:0] m_hl;
  logic [63:0] m_hts;
  int          m_wr = 0, m_rd = 0, m_ign = 0, m_frames = 0;

  function automatic void model_reset();
    q.delete();
    m_armed = 0; m_commit_edge = -1;
    m_wr = 0; m_rd = 0; m_ign = 0; m_frames = 0;
  endfunction

  // Advance the model by one clock edge, given the inputs sampled at that edge.
  function automatic void model_edge(bit en, bit cmp, logic [11:0] len,
                                     logic [63:0] ts, bit rel);
    int     cnt0 = q.size();
    bit     do_commit;
    frame_t f;
    m_k++;
    do_commit = (m_commit_edge == m_k);
    if (cmp && !m_armed) m_ign++;
    if (rel && cnt0 != 0) begin
      void'(q.pop_front());
      m_rd = (m_rd + 1) % N;
    end
    if (m_armed) begin
      if (cmp) begin
        m_hl = len; m_hts = ts; m_commit_edge = m_k + 1; m_armed = 0;
      end else if (!en) begin
        m_armed = 0;
      end
    end else if (do_commit) begin
      f.len = m_hl; f.ts = m_hts; f.slot = m_wr;
      q.push_back(f);
      m_wr = (m_wr + 1) % N;
      m_frames++;
    end else if (m_commit_edge >= 0 && m_k <= m_commit_edge + G) begin
      // guard interval: nothing may arm yet
    end else if (en && cnt0 < N) begin
      m_armed = 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("rx_empty", 64'(rx_empty), 64'(m_armed));
    chk("rx_slot_sel", 64'(rx_slot_sel), 64'(m_wr));
    chk("host_rx_valid", 64'(host_rx_valid), 64'(q.size() != 0));
    chk("host_rx_slot", 64'(host_rx_slot), 64'(m_rd));
    chk("rx_count", 64'(rx_count), 64'(q.size()));
    if (q.size() != 0) begin
      chk("host_rx_slot_q", 64'(host_rx_slot), 64'(q[0].slot));
      chk("host_rx_len", 64'(host_rx_len), 64'(q[0].len));
      chk("host_rx_ts", host_rx_ts, q[0].ts);
    end
`ifdef ETHPIPE_RX_STATS_EN
    chk("stat_rx_frames", 64'(stat_rx_frames), 64'(m_frames));
    chk("stat_rx_ignored", 64'(stat_rx_ignored), 64'(m_ign));
`endif
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit cmp, input logic [11:0] len, input logic [63:0] ts,
                      input bit rel);
    rx_complete = cmp; rx_frame_len = len; rx_timestamp = ts; host_rx_release = rel;
    model_edge(rx_enable, cmp, len, ts, rel);
    @(posedge clk);
    #1;
    rx_complete = 1'b0; host_rx_release = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 12'd0, 64'd0, 1'b0);
  endtask

  task automatic wait_armed();
    int n = 0;
    while (!m_armed && n < 60) begin
      idle(1);
      n++;
    end
    chk("arm_wait_rx_empty", 64'(rx_empty), 64'd1);
  endtask

  task automatic send_frame(input logic [11:0] len, input logic [63:0] ts);
    wait_armed();
    step(1'b1, len, ts, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_rx_empty", 64'(rx_empty), 64'd0);
    chk("rst_rx_slot_sel", 64'(rx_slot_sel), 64'd0);
    chk("rst_host_rx_valid", 64'(host_rx_valid), 64'd0);
    chk("rst_host_rx_slot", 64'(host_rx_slot), 64'd0);
    chk("rst_host_rx_len", 64'(host_rx_len), 64'd0);
    chk("rst_host_rx_ts", host_rx_ts, 64'd0);
    chk("rst_rx_count", 64'(rx_count), 64'd0);
`ifdef ETHPIPE_RX_STATS_EN
    chk("rst_stat_frames", 64'(stat_rx_frames), 64'd0);
    chk("rst_stat_ignored", 64'(stat_rx_ignored), 64'd0);
`endif
    model_reset();
    #1 sys_rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    async_reset();

    // Single frame: timing of rx_empty drop, descriptor visibility and re-arm.
    rx_enable = 1'b1;
    idle(1);
    chk("arm_after_reset", 64'(rx_empty), 64'd1);
    step(1'b1, 12'd64, 64'h100, 1'b0);
    chk("empty_drop", 64'(rx_empty), 64'd0);
    chk("valid_not_yet", 64'(host_rx_valid), 64'd0);
    idle(1);
    chk("first_valid", 64'(host_rx_valid), 64'd1);
    chk("first_slot", 64'(host_rx_slot), 64'd0);
    chk("first_len", 64'(host_rx_len), 64'd64);
    chk("first_ts", host_rx_ts, 64'h100);
    chk("first_sel", 64'(rx_slot_sel), 64'd1);
    idle(G);
    chk("guard_still_low", 64'(rx_empty), 64'd0);
    idle(1);
    chk("rearm_high", 64'(rx_empty), 64'd1);

    // Fill all slots without releasing.
    for (int i = 1; i < N; i++) send_frame(12'(100 + i), 64'(32'h1000 + i));
    idle(10);
    chk("full_count", 64'(rx_count), 64'd4);
    chk("full_empty_low", 64'(rx_empty), 64'd0);
    step(1'b0, 12'd0, 64'd0, 1'b1);
    chk("rel_count", 64'(rx_count), 64'd3);
    chk("rel_rd_ptr", 64'(host_rx_slot), 64'd1);
    idle(1);
    chk("rearm_after_rel", 64'(rx_empty), 64'd1);
    chk("sel_wrap", 64'(rx_slot_sel), 64'd0);

    // Commit and release on the same edge with two pending.
    step(1'b0, 12'd0, 64'd0, 1'b1);
    chk("pre_sim_count", 64'(rx_count), 64'd2);
    step(1'b1, 12'd777, 64'hABCD_0000_1234, 1'b0);
    step(1'b0, 12'd0, 64'd0, 1'b1);
    chk("sim_count", 64'(rx_count), 64'd2);
    chk("sim_rd_ptr", 64'(host_rx_slot), 64'd3);
    chk("sim_wr_ptr", 64'(rx_slot_sel), 64'd1);
    chk("sim_order_len", 64'(host_rx_len), 64'd103);

    // Pulses outside ARMED: once in GUARD, once in HOLD with the receiver disabled.
    step(1'b1, 12'd55, 64'h55, 1'b0);
    rx_enable = 1'b0;
    idle(8);
    step(1'b1, 12'd66, 64'h66, 1'b0);
    idle(1);
    chk("ign_count", 64'(rx_count), 64'd2);
    chk("ign_len", 64'(host_rx_len), 64'd103);
`ifdef ETHPIPE_RX_STATS_EN
    chk("stat_ignored_2", 64'(stat_rx_ignored), 64'd2);
`endif

    // Drain, then release with nothing pending.
    step(1'b0, 12'd0, 64'd0, 1'b1);
    step(1'b0, 12'd0, 64'd0, 1'b1);
    step(1'b0, 12'd0, 64'd0, 1'b1);
    chk("empty_rel_count", 64'(rx_count), 64'd0);
    chk("empty_rel_valid", 64'(host_rx_valid), 64'd0);
    chk("empty_rel_rd", 64'(host_rx_slot), 64'd1);

    // Randomized traffic, alternating light and heavy release pressure.
    for (int i = 0; i < 800; i++) begin
      rx_enable = ($urandom % 8) != 0;
      step(($urandom % 3) == 0, 12'($urandom), {$urandom, $urandom},
           ((i / 100) % 2) ? (($urandom % 2) == 0) : (($urandom % 7) == 0));
    end

    // Reset in GUARD with three pending frames.
    async_reset();
    rx_enable = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(12'(200 + i), 64'(32'h2000 + i));
    idle(1);
    chk("pre_rst_count", 64'(rx_count), 64'd3);
    async_reset();
    idle(1);
    chk("post_rst_arm", 64'(rx_empty), 64'd1);
    chk("post_rst_count", 64'(rx_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
